// File: rtl/arp_engine_pkg.sv
// Shared types for the ARP engine: the received Ethernet header as seen by the parser.
package arp_engine_pkg;

    typedef struct packed {
        logic [47:0] mac_destination;
        logic [47:0] mac_source;
        logic [15:0] ether_type;
    } st_eth_header;

endpackage

// File: rtl/arp_engine.sv
// ARP responder: parses one ARP body, learns sender bindings into a round-robin cache,
// answers requests for MY_IP with a padded reply frame and serves single-cycle cache lookups.
module arp_engine
    import arp_engine_pkg::*;
#(
    parameter logic [47:0] MY_MAC      = 48'h12_34_56_78_9a_bc,
    parameter logic [31:0] MY_IP       = 32'hc0_a8_00_01,
    parameter int          CACHE_DEPTH = 4,
    parameter int          PAD_BYTES   = 18
) (
    input  logic         eth_clk,
    input  logic         rst_n_in,
    input  logic         active,
    input  st_eth_header eth_header,
    input  logic [7:0]   data_rxd,
    input  logic         data_new,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_last,
    input  logic         tx_ready,
    input  logic         lookup_req,
    input  logic [31:0]  lookup_ip,
    output logic         lookup_done,
    output logic         lookup_hit,
    output logic [47:0]  lookup_mac,
    output logic         finished,
    output logic         rx_error
);

    localparam int TX_LEN = 42 + PAD_BYTES;
    localparam int IDX_W  = $clog2(TX_LEN);
    localparam int PTR_W  = $clog2(CACHE_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_LEN - 1);
    localparam logic [47:0]      BCAST    = 48'hff_ff_ff_ff_ff_ff;

    typedef enum logic [2:0] {IDLE, PARSE, DECIDE, TX, DONE} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CACHE_DEPTH-1:0] valid_q, valid_d;
    logic                   lk_done_q, lk_hit_q;
    logic [47:0]            lk_mac_q;

    // Datapath storage: never read before being written under control of the FSM.
    logic [223:0] hdr_q;
    logic [47:0]  dst_q;
    logic [31:0]  ip_q  [CACHE_DEPTH];
    logic [47:0]  mac_q [CACHE_DEPTH];

    logic [15:0] htype, ptype, oper;
    logic [7:0]  hlen, plen;
    logic [47:0] sha;
    logic [31:0] spa, tpa;
    logic        well_formed, need_reply, do_learn;
    logic        learn_hit, lk_hit;
    logic [PTR_W-1:0] learn_idx, wr_idx;
    logic [47:0] lk_mac;
    logic        unused_bits;

    assign htype = hdr_q[223:208];
    assign ptype = hdr_q[207:192];
    assign hlen  = hdr_q[191:184];
    assign plen  = hdr_q[183:176];
    assign oper  = hdr_q[175:160];
    assign sha   = hdr_q[159:112];
    assign spa   = hdr_q[111:80];
    assign tpa   = hdr_q[31:0];

    assign unused_bits = ^{hdr_q[79:32], eth_header.mac_source, eth_header.ether_type};

    function automatic logic [7:0] reply_byte(input logic [IDX_W-1:0] idx,
                                              input logic [47:0]      peer_mac,
                                              input logic [31:0]      peer_ip);
        logic [335:0] body;
        logic [335:0] shifted;
        body = {peer_mac, MY_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                MY_MAC, MY_IP, peer_mac, peer_ip};
        // Indices past the 42-byte body shift everything out, which yields the zero padding.
        shifted = body << {idx, 3'b000};
        return shifted[335:328];
    endfunction

    assign well_formed = (htype == 16'h0001) && (ptype == 16'h0800) && (hlen == 8'd6) &&
                         (plen == 8'd4) && ((oper == 16'd1) || (oper == 16'd2));
    assign need_reply  = well_formed && (oper == 16'd1) && (tpa == MY_IP) &&
                         ((dst_q == BCAST) || (dst_q == MY_MAC));
    assign do_learn    = (state_q == DECIDE) && well_formed && (spa != 32'd0);

    always_comb begin
        learn_hit = 1'b0;
        learn_idx = '0;
        lk_hit    = 1'b0;
        lk_mac    = '0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            if (!learn_hit && valid_q[i] && (ip_q[i] == spa)) begin
                learn_hit = 1'b1;
                learn_idx = PTR_W'(i);
            end
            if (!lk_hit && valid_q[i] && (lookup_ip != 32'd0) && (ip_q[i] == lookup_ip)) begin
                lk_hit = 1'b1;
                lk_mac = mac_q[i];
            end
        end
    end

    assign wr_idx = learn_hit ? learn_idx : ptr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (active) begin
                    state_d = PARSE;
                    cnt_d   = '0;
                end
            end
            PARSE: begin
                if (!active) begin
                    state_d = IDLE;
                end else if (data_new) begin
                    if (cnt_q == 5'd27) begin
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DECIDE: begin
                if (do_learn && !learn_hit) begin
                    valid_d[ptr_q] = 1'b1;
                    ptr_d          = ptr_q + 1'b1;
                end
                if (need_reply) begin
                    state_d = TX;
                    idx_d   = '0;
                end else begin
                    state_d = DONE;
                end
            end
            TX: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!active) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge eth_clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            valid_q   <= '0;
            lk_done_q <= 1'b0;
            lk_hit_q  <= 1'b0;
            lk_mac_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            lk_done_q <= lookup_req;
            if (lookup_req) begin
                lk_hit_q <= lk_hit;
                lk_mac_q <= lk_mac;
            end
        end
    end

    // Lookups sample the cache before a same-edge learn write lands.
    always_ff @(posedge eth_clk) begin
        if ((state_q == IDLE) && active) begin
            dst_q <= eth_header.mac_destination;
        end
        if ((state_q == PARSE) && active && data_new) begin
            hdr_q <= {hdr_q[215:0], data_rxd};
        end
        if (do_learn) begin
            ip_q[wr_idx]  <= spa;
            mac_q[wr_idx] <= sha;
        end
    end

    assign tx_valid    = (state_q == TX);
    assign tx_last     = tx_valid && (idx_q == LAST_IDX);
    assign tx_data     = tx_valid ? reply_byte(idx_q, sha, spa) : 8'h00;
    assign finished    = (state_q == DONE);
    assign rx_error    = (state_q == DECIDE) && !well_formed;
    assign lookup_done = lk_done_q;
    assign lookup_hit  = lk_hit_q;
    assign lookup_mac  = lk_mac_q;

endmodule
